// File: rtl/bmem_arb.sv
// Two-way round-robin line-fill arbiter: imem (_i) and dmem (_d) share one external
// line-read port; an abandoned fill is drained before the port is granted again.
//
// state  | meaning
// IDLE   | port free, arbitrate pending requests
// BUSY_I | fill in flight for imem, dv forwarded to imem
// BUSY_D | fill in flight for dmem, dv forwarded to dmem
// DRAIN  | client abandoned its fill, wait for the bus to answer
module bmem_arb #(
  parameter int BLK_LEN = 58,
  parameter int LINE    = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] b_addr_i,
  input  logic               b_rd_i,
  output logic               b_dv_i,
  output logic [LINE-1:0]    b_rdata_i,
  input  logic [BLK_LEN-1:0] b_addr_d,
  input  logic               b_rd_d,
  output logic               b_dv_d,
  output logic [LINE-1:0]    b_rdata_d,
  output logic [BLK_LEN-1:0] b_addr,
  output logic               b_rd,
  input  logic [LINE-1:0]    b_rdata,
  input  logic               b_dv
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;   // 0: imem served last, 1: dmem served last
  logic [BLK_LEN-1:0]   addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (b_rd_d && (!b_rd_i || !last_q)) begin
          state_d = BUSY_D;
          addr_d  = b_addr_d;
          last_d  = 1'b1;
        end else if (b_rd_i) begin
          state_d = BUSY_I;
          addr_d  = b_addr_i;
          last_d  = 1'b0;
        end
      end
      BUSY_I: begin
        if (b_dv)         state_d = IDLE;
        else if (!b_rd_i) state_d = DRAIN;
      end
      BUSY_D: begin
        if (b_dv)         state_d = IDLE;
        else if (!b_rd_d) state_d = DRAIN;
      end
      DRAIN: begin
        if (b_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  // b_rd comes straight from the state flops so it cannot glitch
  assign b_rd      = (state_q != IDLE);
  assign b_addr    = addr_q;
  assign b_dv_i    = (state_q == BUSY_I) && b_dv && b_rd_i;
  assign b_dv_d    = (state_q == BUSY_D) && b_dv && b_rd_d;
  assign b_rdata_i = b_rdata;
  assign b_rdata_d = b_rdata;

endmodule
